// File: rtl/lifo_reader.sv
// Pops a burst of words from a LIFO read port into a 2-entry ready/valid output buffer.
// Define LIFO_READER_ABORT_EN to add the abort_i input that ends a burst early.
module lifo_reader #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              start_i,
    input  logic [AWIDTH:0]   len_i,
    output logic              lifo_rdreq_o,
    input  logic [DWIDTH-1:0] lifo_q_i,
    input  logic              lifo_empty_i,
    input  logic [AWIDTH:0]   lifo_usedw_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [AWIDTH:0]   count_o
`ifdef LIFO_READER_ABORT_EN
    ,
    input  logic              abort_i
`endif
);

    localparam int unsigned CW = AWIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     len_q;
    logic [CW-1:0]     pops_q;
    logic              rdreq_q;
    logic [DWIDTH-1:0] skid_data;
    logic              skid_valid;

    logic              abort;
    logic              xfer;
    logic              pop;
    logic [1:0]        occ_next;
    logic [CW-1:0]     pops_next;

`ifdef LIFO_READER_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // Pop decision: occ_next is buffered words plus the word now on lifo_q_i, after this
    // cycle's transfer; a new pop is allowed only if it still fits in the two entries.
    // usedw lags a pop by a cycle, so a pop last cycle must leave at least one more word.
    always_comb begin
        xfer      = valid_o & ready_i;
        occ_next  = 2'(valid_o) + 2'(skid_valid) + 2'(rdreq_q) - 2'(xfer);
        pop       = 1'b0;
        if ((state == RUN) && !abort && (pops_q < len_q) && !lifo_empty_i &&
            (lifo_usedw_i > CW'(rdreq_q)) && (occ_next < 2'd2)) begin
            pop = 1'b1;
        end
        pops_next = pops_q + CW'(pop);
    end

    assign lifo_rdreq_o = pop;

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state      <= IDLE;
            len_q      <= '0;
            pops_q     <= '0;
            rdreq_q    <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            count_o    <= '0;
        end else begin
            rdreq_q <= pop;
            done_o  <= 1'b0;

            // data_o is the buffer head, skid_data the second entry; order follows pop order.
            if (xfer) begin
                if (skid_valid) begin
                    data_o     <= skid_data;
                    valid_o    <= 1'b1;
                    skid_valid <= rdreq_q;
                    if (rdreq_q) begin
                        skid_data <= lifo_q_i;
                    end
                end else begin
                    valid_o <= rdreq_q;
                    if (rdreq_q) begin
                        data_o <= lifo_q_i;
                    end
                end
            end else if (rdreq_q) begin
                if (!valid_o) begin
                    data_o  <= lifo_q_i;
                    valid_o <= 1'b1;
                end else begin
                    skid_data  <= lifo_q_i;
                    skid_valid <= 1'b1;
                end
            end

            if (xfer && (count_o < len_q)) begin
                count_o <= count_o + CW'(1);
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        len_q   <= len_i;
                        pops_q  <= '0;
                        count_o <= '0;
                        busy_o  <= 1'b1;
                        if (len_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    pops_q <= pops_next;
                    if (abort || (pops_next == len_q) || (lifo_empty_i && !rdreq_q)) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (occ_next == 2'd0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lifo_reader.md
LIFO_READER -- requirements
Module: lifo_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, meaning the data word width.
REQ-002 SHALL have parameter AWIDTH, default 8, meaning the LIFO address width; depth is 2**AWIDTH.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port srst_i, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port start_i, input, 1, a one-cycle burst request, sampled in IDLE only.
REQ-006 SHALL have port len_i, input, AWIDTH+1, the burst length in words, latched with start_i.
REQ-007 SHALL have port lifo_rdreq_o, output, 1, the pop request to the LIFO read port.
REQ-008 SHALL have port lifo_q_i, input, DWIDTH, the LIFO read data, valid 1 cycle after lifo_rdreq_o.
REQ-009 SHALL have port lifo_empty_i, input, 1, the LIFO empty flag.
REQ-010 SHALL have port lifo_usedw_i, input, AWIDTH+1, the LIFO fill level, updated 1 cycle after each pop.
REQ-011 SHALL have port data_o, output, DWIDTH, the downstream data.
REQ-012 SHALL have port valid_o, output, 1, the downstream valid.
REQ-013 SHALL have port ready_i, input, 1, the downstream ready; a transfer occurs when valid_o and ready_i are both high.
REQ-014 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port done_o, output, 1, a one-cycle pulse at burst end.
REQ-016 SHALL have port count_o, output, AWIDTH+1, the number of words delivered downstream in the last or current burst.

Function
REQ-017 SHALL implement FSM IDLE->RUN->FLUSH->DONE->IDLE.
REQ-018 IDLE: on start_i=1, latch len_i, clear count_o, and go to RUN; start_i=1 with len_i=0 SHALL go directly to DONE.
REQ-019 RUN: assert lifo_rdreq_o only when all three hold: pops issued < latched len; lifo_empty_i=0; lifo_usedw_i > (lifo_rdreq_o of the previous cycle ? 1 : 0).
REQ-020 The FSM SHALL never pop an empty LIFO, including on back-to-back pops at usedw=1.
REQ-021 SHALL hold a 2-entry output buffer; in-flight pops plus buffered words SHALL never exceed 2, so a full buffer with ready_i=0 stops popping.
REQ-022 Each popped word SHALL be captured into the buffer the cycle after its lifo_rdreq_o; output order SHALL equal pop order.
REQ-023 With ready_i held at 1, SHALL sustain 1 word/cycle; first-pop-to-valid_o latency SHALL be 2 cycles (pop, capture, register).
REQ-024 data_o SHALL stay stable while valid_o=1 and ready_i=0.
REQ-025 count_o SHALL increment on each downstream transfer and saturate at len.
REQ-026 RUN->FLUSH when pops issued = len, or when the LIFO is empty with no pop in flight (short burst).
REQ-027 FLUSH->DONE when the buffer is empty and no pop is in flight.
REQ-028 DONE SHALL last 1 cycle with done_o=1, then return to IDLE; count_o SHALL hold its value until the next start.
REQ-029 start_i outside IDLE SHALL be ignored.

Reset
REQ-030 On srst_i=1, at any time and including mid-burst, SHALL asynchronously force state=IDLE, lifo_rdreq_o=0, valid_o=0, busy_o=0, done_o=0, count_o=0, data_o=0, and empty the buffer.
REQ-031 After srst_i deasserts, SHALL accept start_i on the first clock edge.

Configuration
REQ-032 Macro LIFO_READER_ABORT_EN: when defined, add input abort_i (1 bit).
REQ-033 With LIFO_READER_ABORT_EN defined, abort_i=1 in RUN SHALL stop new pops immediately and go to FLUSH; buffered and in-flight words SHALL still be delivered, and count_o SHALL reflect only delivered words.
REQ-034 When LIFO_READER_ABORT_EN is undefined, the abort_i port SHALL be absent and behaviour SHALL be identical to abort_i tied 0.

Verification
REQ-035 LIFO holds 5,6,7 (7 on top), len=3, ready=1 -> data_o 7,6,5 on consecutive cycles; done_o 1 cycle after the last transfer; count_o=3.
REQ-036 LIFO holds 2 words, len=4 -> exactly 2 pops with no pop while empty; done_o pulses; count_o=2.
REQ-037 len=8, LIFO depth full, ready_i toggling 1010... -> no word lost or duplicated; at most 2 words outstanding; count_o=8.
REQ-038 len=0 start -> no lifo_rdreq_o; done_o on the next cycle; count_o=0.
REQ-039 srst_i asserted mid-burst after 3 transfers -> all outputs 0 asynchronously; a new start with len=2 then works normally.
REQ-040 With LIFO_READER_ABORT_EN defined: len=10, abort_i after 4 pops -> pops stop; 4 words delivered; count_o=4; done_o pulses.
